if_id_buffer: RTL

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/riscv_pkg.sv | 15 +
 rtl/if_id_buffer.sv | 98 +++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: datapath width, the canonical NOP, and the
// fetch-entry record carried from IF to ID.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: a small circular FIFO of {pc, instruction} pairs
// between fetch and decode, with flush on taken branches and a NOP when empty.
module if_id_buffer
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = riscv_pkg::XLEN
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [XLEN-1:0]          pcIn,
    input  logic [XLEN-1:0]          instructionIn,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic                     flush,
    output logic [XLEN-1:0]          pcOut,
    output logic [XLEN-1:0]          instructionOut,
    output logic [XLEN-1:0]          pcPlus4Out,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Entry record sized by this instance's XLEN so width overrides stay consistent.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
    } entry_t;

    entry_t             entries_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               push, pop;
    entry_t             head;

    assign inReady  = (count_q < CNT_W'(DEPTH));
    assign outValid = (count_q != '0);
    assign count    = count_q;

    assign push = inValid  && inReady  && !flush;
    assign pop  = outValid && outReady && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never observed while count is zero, so it carries no reset.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            entries_q[wr_ptr_q] <= '{pc: pcIn, instruction: instructionIn};
        end
    end

    assign head = entries_q[rd_ptr_q];

    always_comb begin
        pcOut          = '0;
        instructionOut = XLEN'(NOP_INSTR);
        if (outValid) begin
            pcOut          = head.pc;
            instructionOut = head.instruction;
        end
    end

    assign pcPlus4Out = pcOut + XLEN'(4);

endmodule
